mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 28 ++
 rtl/mul_div_unit_step.sv | 47 ++++
 rtl/mul_div_unit.sv | 138 +++++++++++++
 tb/tb_mul_div_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: op codes, FSM state codes, default widths.
// The divide datapath is present only when MUL_DIV_UNIT_DIV_EN is defined.
`ifndef RegWidth
`define RegWidth 16
`endif
`ifndef NumRegsWidth
`define NumRegsWidth 5
`endif

package mul_div_unit_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_MUL  = 2'b00;
  localparam op_t OP_MULH = 2'b01;
  localparam op_t OP_DIVU = 2'b10;
  localparam op_t OP_REMU = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_WB   = 2'b10;

  // The upper op bit selects the divide family.
  function automatic logic isDivOp(input op_t opCode);
    return opCode[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One iteration of the datapath: shift-add for multiply, restoring shift-subtract for divide.
// The divide half only exists when MUL_DIV_UNIT_DIV_EN is defined.
`ifndef RegWidth
`define RegWidth 16
`endif

module muldiv_step #(
  parameter int W = `RegWidth
) (
`ifdef MUL_DIV_UNIT_DIV_EN
  input  logic         divMode_i,
`endif
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] operand_i,
  output logic [W-1:0] hiNext_o,
  output logic [W-1:0] loNext_o
);

  logic [W:0] sum;
`ifdef MUL_DIV_UNIT_DIV_EN
  logic [W:0] shifted;
  logic [W:0] diff;
`endif

  // Multiply: hi accumulates the partial product, lo holds the unconsumed multiplier bits;
  // the carry out of the add drops into the top of the shifted pair.
  always_comb begin
    sum      = {1'b0, hi_i} + {1'b0, (lo_i[0] ? operand_i : {W{1'b0}})};
    hiNext_o = sum[W:1];
    loNext_o = {sum[0], lo_i[W-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
    shifted = {hi_i, lo_i[W-1]};
    diff    = shifted - {1'b0, operand_i};
    if (divMode_i) begin
      if (shifted >= {1'b0, operand_i}) begin
        hiNext_o = diff[W-1:0];
        loNext_o = {lo_i[W-2:0], 1'b1};
      end else begin
        hiNext_o = shifted[W-1:0];
        loNext_o = {lo_i[W-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: IDLE -> RUN (W iterations) -> WB, one register write per op.
// Define MUL_DIV_UNIT_DIV_EN to include DIVU/REMU; otherwise those ops write zero immediately.
`ifndef RegWidth
`define RegWidth 16
`endif
`ifndef NumRegsWidth
`define NumRegsWidth 5
`endif

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int W  = `RegWidth,
  parameter int RW = `NumRegsWidth
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [W-1:0]  rs_val,
  input  logic [W-1:0]  rt_val,
  input  logic [RW-1:0] rd_in,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] rd,
  output logic [W-1:0]  reg_in,
  output logic          reg_write_en
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  operand_q, operand_d;
  op_t           op_q, op_d;
  logic [RW-1:0] rd_q, rd_d;

  logic [W-1:0]  stepHi, stepLo;
  logic [W-1:0]  result;
  logic          inWb;

  muldiv_step #(.W(W)) uStep (
`ifdef MUL_DIV_UNIT_DIV_EN
    .divMode_i (isDivOp(op_q)),
`endif
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .operand_i (operand_q),
    .hiNext_o  (stepHi),
    .loNext_o  (stepLo)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      operand_q <= '0;
      op_q      <= OP_MUL;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
    end
  end

  // Multiply seeds lo with the multiplier, divide seeds it with the dividend; hi starts clear.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    operand_d = operand_q;
    op_d      = op_q;
    rd_d      = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          rd_d    = rd_in;
          hi_d    = '0;
          count_d = '0;
          if (isDivOp(op)) begin
            lo_d      = rs_val;
            operand_d = rt_val;
          end else begin
            lo_d      = rt_val;
            operand_d = rs_val;
          end
`ifdef MUL_DIV_UNIT_DIV_EN
          state_d = ST_RUN;
`else
          state_d = isDivOp(op) ? ST_WB : ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        hi_d    = stepHi;
        lo_d    = stepLo;
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:  result = lo_q;
      OP_MULH: result = hi_q;
`ifdef MUL_DIV_UNIT_DIV_EN
      OP_DIVU: result = lo_q;
      OP_REMU: result = hi_q;
`endif
      default: result = '0;
    endcase
  end

  // Reset suppresses the write combinationally so an abort in WB never reaches the register file.
  assign inWb         = (state_q == ST_WB) && !RST;
  assign busy         = (state_q != ST_IDLE);
  assign done         = inWb;
  assign reg_write_en = inWb;
  assign rd           = inWb ? rd_q : '0;
  assign reg_in       = inWb ? result : '0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (W=16): vector table, hand-written corner sequences, random ops.
// Expectations follow MUL_DIV_UNIT_DIV_EN when it is defined for the build.
module tb_mul_div_unit;

  localparam logic [1:0] MUL  = 2'b00;
  localparam logic [1:0] MULH = 2'b01;
  localparam logic [1:0] DIVU = 2'b10;
  localparam logic [1:0] REMU = 2'b11;
`ifdef MUL_DIV_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  rd;
    logic [15:0] expRes;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] rsVal, rtVal;
  logic [4:0]  rdIn;
  logic        busy, done, regWriteEn;
  logic [4:0]  rd;
  logic [15:0] regIn;

  int checkCount = 0;
  int passCount  = 0;
  vec_t vecs[$];

  mul_div_unit #(.W(16), .RW(5)) dut (
    .CLK          (clk),
    .RST          (rst),
    .start        (start),
    .op           (op),
    .rs_val       (rsVal),
    .rt_val       (rtVal),
    .rd_in        (rdIn),
    .busy         (busy),
    .done         (done),
    .rd           (rd),
    .reg_in       (regIn),
    .reg_write_en (regWriteEn)
  );

  always #5 clk = ~clk;

  // Reference: plain 32-bit arithmetic, divide-by-zero rules, zero result when divide is absent.
  function automatic logic [15:0] refModel(input logic [1:0] o, input logic [15:0] a,
                                           input logic [15:0] b);
    longint unsigned prod = longint'(a) * longint'(b);
    case (o)
      MUL:     return prod[15:0];
      MULH:    return prod[31:16];
      DIVU:    return !DIV_EN ? 16'h0 : (b == 0 ? 16'hFFFF : a / b);
      default: return !DIV_EN ? 16'h0 : (b == 0 ? a : a % b);
    endcase
  endfunction

  function automatic int expLatency(input logic [1:0] o);
    return (o[1] && !DIV_EN) ? 1 : 17;
  endfunction

  function automatic vec_t mkVec(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] r, input logic [15:0] e);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.rd = r; v.expRes = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [15:0] a,
                               input logic [15:0] b, input logic [4:0] r);
    start = s; op = o; rsVal = a; rtVal = b; rdIn = r;
  endtask

  // Issue one op at a negedge, scramble inputs afterwards, then wait (bounded) for the write.
  task automatic runOp(input string name, input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] r, input logic [15:0] expRes);
    int cycles;
    int idleSeen;
    applyStimulus(1'b1, o, a, b, r);
    @(negedge clk);
    applyStimulus(1'b0, 2'($urandom), 16'($urandom), 16'($urandom), 5'($urandom));
    cycles = 1;
    idleSeen = 0;
    while (!regWriteEn && cycles < 40) begin
      if (!busy) idleSeen++;
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, ".latency"}, cycles, expLatency(o));
    checkOutput({name, ".busyRun"}, idleSeen + (busy ? 0 : 1), 0);
    checkOutput({name, ".done"}, done, 1);
    checkOutput({name, ".rd"}, rd, r);
    checkOutput({name, ".result"}, regIn, expRes);
    @(negedge clk);
    checkOutput({name, ".afterWe"}, {busy, done, regWriteEn, rd, regIn}, 0);
  endtask

  initial begin
    int writes;

    vecs.push_back(mkVec(MUL,  16'd7,    16'd6,    5'd3,  16'd42));
    vecs.push_back(mkVec(MULH, 16'hFFFF, 16'hFFFF, 5'd4,  16'hFFFE));
    vecs.push_back(mkVec(MUL,  16'hFFFF, 16'hFFFF, 5'd5,  16'h0001));
    vecs.push_back(mkVec(MULH, 16'h1234, 16'h0100, 5'd0,  16'h0012));
`ifdef MUL_DIV_UNIT_DIV_EN
    vecs.push_back(mkVec(DIVU, 16'd100,  16'd7,    5'd6,  16'd14));
    vecs.push_back(mkVec(REMU, 16'd100,  16'd7,    5'd7,  16'd2));
    vecs.push_back(mkVec(DIVU, 16'd5,    16'd0,    5'd8,  16'hFFFF));
    vecs.push_back(mkVec(REMU, 16'd5,    16'd0,    5'd0,  16'd5));
    vecs.push_back(mkVec(DIVU, 16'hFFFF, 16'd1,    5'd31, 16'hFFFF));
`else
    vecs.push_back(mkVec(DIVU, 16'd100,  16'd7,    5'd2,  16'd0));
    vecs.push_back(mkVec(REMU, 16'd100,  16'd7,    5'd0,  16'd0));
`endif

    applyStimulus(1'b0, MUL, 16'd0, 16'd0, 5'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("resetHeld", {busy, done, regWriteEn, rd, regIn}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetReleased", {busy, done, regWriteEn, rd, regIn}, 0);

    for (int i = 0; i < vecs.size(); i++)
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
            vecs[i].expRes);

    // start pulses at cycle 3 (RUN) and cycle 17 (WB) must be ignored.
    applyStimulus(1'b1, MUL, 16'd7, 16'd6, 5'd3);
    writes = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 3 || c == 17) applyStimulus(1'b1, MULH, 16'hFFFF, 16'hFFFF, 5'd9);
      else applyStimulus(1'b0, MUL, 16'd0, 16'd0, 5'd0);
      if (regWriteEn) begin
        writes++;
        checkOutput("ignoreStart.cycle", c, 17);
        checkOutput("ignoreStart.result", {rd, regIn}, {5'd3, 16'd42});
      end
      if (c == 18) checkOutput("ignoreStart.idleAfterWb", busy, 0);
    end
    checkOutput("ignoreStart.writes", writes, 1);

    // Reset in the middle of a running op: no write, unit idle, next op clean.
    applyStimulus(1'b1, DIV_EN ? DIVU : MULH, 16'd1000, 16'd3, 5'd12);
    @(negedge clk);
    applyStimulus(1'b0, MUL, 16'd0, 16'd0, 5'd0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("abortRun.weDuringRst", {regWriteEn, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortRun.busy", busy, 0);
    writes = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (regWriteEn) writes++;
    end
    checkOutput("abortRun.writes", writes, 0);
    runOp("afterAbort", MUL, 16'd3, 16'd3, 5'd1, 16'd9);

    // Reset while in WB must suppress that cycle's write.
    applyStimulus(1'b1, MUL, 16'd2, 16'd2, 5'd10);
    @(negedge clk);
    applyStimulus(1'b0, MUL, 16'd0, 16'd0, 5'd0);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("abortWb.we", {regWriteEn, done, rd, regIn}, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortWb.busy", busy, 0);

    // Reset wins over start at the same edge.
    rst = 1'b1;
    applyStimulus(1'b1, MUL, 16'd5, 16'd5, 5'd2);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, MUL, 16'd0, 16'd0, 5'd0);
    checkOutput("rstPriority.busy", busy, 0);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  o;
      logic [15:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 12));
      runOp($sformatf("rand%0d", i), o, a, b, 5'($urandom), refModel(o, a, b));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
